fsm_7_tx: RTL
=============

# fsm_7_tx

Transmitter for the fsm_7 serial sequence detector. It drives the detector's one-bit input `x` every clock so that the detector's `y` output fires exactly the commanded number of times, with an optional programmable idle gap between pulses. The block keeps a mirror of the detector's 2-bit state. It must be reset in the same cycle as the detector it drives, because that state cannot be recovered from the bit stream.

## Interface
- `CNT_W`, default 8: width of the pulse count.
- `GAP_W`, default 4: width of the gap length.
- `clk` input 1: single clock; all logic on its rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `cmd_valid` input 1: command request.
- `cmd_ready` output 1: command accepted when `cmd_valid && cmd_ready`.
- `cmd_count` input `CNT_W`: number of detector pulses to generate (0..2^CNT_W-1).
- `cmd_gap` input `GAP_W`: number of `x=0` cycles inserted between consecutive pulses.
- `x` output 1: registered serial bit to the detector.
- `pulse_mark` output 1: high in the cycle `x` carries the bit on which the detector asserts `y`.
- `done` output 1: one-cycle pulse when a command completes.
- `busy` output 1: high from the cycle after acceptance until `done`.

## Operation
- **Mirror state `s[1:0]`.** Updated every cycle, including idle, from the `x` currently driven. `x=0` toggles `s[0]`; `x=1` toggles `s[1]`. The detector's `y` is `(s==2'b11) && x`.
- **Bit selection.** Each driven bit is chosen from `s` at the start of that bit's cycle.
- **FSM states:**
  - IDLE: `x=0`, `cmd_ready=1`. On accept, latch count and gap, then go to SETUP; with count 0, go to IDLE and assert `done` instead.
  - SETUP: if `s[1]==0`, drive 1. Otherwise, if `s[0]==0`, drive 0. Once `s==11` at cycle start, go to FIRE without emitting a bit (the FIRE bit is the next bit).
  - FIRE: drive `x=1` with `pulse_mark=1`, then decrement remaining. If remaining becomes 0, go to IDLE with `done`. Otherwise go to GAP if gap>0, else SETUP.
  - GAP: drive `x=0` for gap cycles, then go to SETUP.
- **Token length:**
  - From `s=00`: `1,0,1`.
  - From `s=10`: `0,1`.
  - From `s=01`: `1,1`.
  - From `s=11`: `1`.
  - After every FIRE, `s=01`.
- **Arithmetic.** The remaining counter is `CNT_W` bits and never wraps; it is decremented only in FIRE. The gap counter is `GAP_W` bits and reloads from the latched gap at each FIRE.
- **Commands while busy.** `cmd_valid` while busy is ignored, with no queueing. Command inputs are sampled only on accept.
- **Reset.** Reset mid-command aborts immediately, with no `done` or `pulse_mark`. The detector is reset in the same cycle.

## Timing
- **Reset values:** `x=0`, `pulse_mark=0`, `done=0`, `busy=0`, `cmd_ready=1`, `s=00`, FSM=IDLE.
- **First bit.** The first token bit is driven in the cycle after accept. The bit driven in the accept cycle is the idle 0, which does update `s`.
- **Pulse latency.** The detector's `y` coincides with `pulse_mark`: `y` is combinational from the detector state and the registered `x`.
- **Completion.** `done` and `cmd_ready=1` appear in the cycle after the last FIRE, and `busy=0` in that same cycle. A new command may be accepted in that cycle.
- **Zero count.** `cmd_count=0`: `done` in the cycle after accept; `x` stays 0 and `busy` is never asserted.
- **Throughput.** With gap 0, steady state is one pulse per 2 cycles.

## Configuration
- `FSM7_TX_GAP_EN` defined: `cmd_gap` is latched and GAP insertion operates as above.
- `FSM7_TX_GAP_EN` undefined: `cmd_gap` is ignored, the GAP state and gap counter are not built, and FIRE goes straight to SETUP.

## Test plan
- **Single pulse after reset.** Release reset; accept `count=1`, `gap=0` in the first cycle. Required: `x=1,1`, `pulse_mark` on the 2nd bit, detector `y` once, `done` the next cycle.
- **Back-to-back pulses.** Accept `count=3`, `gap=0` with `s=01`. Required: `x=1,1,1,1,1,1`, `pulse_mark` on bits 2, 4 and 6, exactly 3 detector `y` pulses.
- **Gap insertion (`FSM7_TX_GAP_EN`).** Accept `count=2`, `gap=1` with `s=01`. Required: `x=1,1,0,1,0,1`, `pulse_mark` on bits 2 and 6, mirror `s` equal to detector state every cycle.
- **Zero count.** Accept `count=0`. Required: `done` the next cycle, `x=0` throughout, no `pulse_mark`, no `y`.
- **Busy and reset abort.** Raise `cmd_valid` during a `count=5` command. Required: ignored, `cmd_ready=0`. Then assert `rst` mid-SETUP. Required next cycle: `x=0`, `cmd_ready=1`, no `done`.
- **Gap ignored (without `FSM7_TX_GAP_EN`).** Accept `count=2`, `gap=5` with `s=01`. Required: `x=1,1,1,1`, 2 pulses.

Source files
------------

// File: rtl/fsm_7_tx.sv
// fsm_7_tx: bit-stream transmitter for the fsm_7 sequence detector.
// Drives the detector's serial input so that its y output fires a commanded
// number of times. Keeps a mirror of the detector's 2-bit state to pick each bit.
// Optional feature macro: FSM7_TX_GAP_EN enables idle-gap insertion between pulses.
module fsm_7_tx #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned GAP_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [CNT_W-1:0] cmd_count_i,
  input  logic [GAP_W-1:0] cmd_gap_i,
  output logic             x_o,
  output logic             pulse_mark_o,
  output logic             done_o,
  output logic             busy_o
);

  // state_q names the rule used to pick the bit driven in the next cycle.
`ifdef FSM7_TX_GAP_EN
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSetup = 2'd1,
    StFire  = 2'd2,
    StGap   = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSetup = 2'd1,
    StFire  = 2'd2
  } state_e;
`endif

  state_e           state_q, state_d;
  logic [1:0]       s_q, s_d;
  logic             x_q, x_d;
  logic             pm_q, pm_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             run_setup;

`ifdef FSM7_TX_GAP_EN
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [GAP_W-1:0] gcnt_q, gcnt_d;
`else
  logic unused_gap;
  assign unused_gap = ^cmd_gap_i;
`endif

  // Next-state, next-bit and mirror-state update.
  always_comb begin
    state_d   = state_q;
    x_d       = 1'b0;
    pm_d      = 1'b0;
    done_d    = 1'b0;
    rem_d     = rem_q;
    run_setup = 1'b0;
`ifdef FSM7_TX_GAP_EN
    gap_d     = gap_q;
    gcnt_d    = gcnt_q;
`endif
    // Detector state at the start of the next cycle, i.e. when x_d is on the wire.
    s_d = s_q ^ (x_q ? 2'b10 : 2'b01);

    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          if (cmd_count_i == '0) begin
            done_d = 1'b1;
          end else begin
            rem_d     = cmd_count_i;
`ifdef FSM7_TX_GAP_EN
            gap_d     = cmd_gap_i;
`endif
            run_setup = 1'b1;
          end
        end
      end
      StSetup: run_setup = 1'b1;
      StFire: begin
        // The fire bit is on the wire now; rem_q still counts it.
        rem_d = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          done_d  = 1'b1;
          state_d = StIdle;
`ifdef FSM7_TX_GAP_EN
        end else if (gap_q != '0) begin
          gcnt_d  = gap_q - GAP_W'(1);
          state_d = (gap_q == GAP_W'(1)) ? StSetup : StGap;
`endif
        end else begin
          run_setup = 1'b1;
        end
      end
`ifdef FSM7_TX_GAP_EN
      StGap: begin
        gcnt_d = gcnt_q - GAP_W'(1);
        if (gcnt_q == GAP_W'(1)) state_d = StSetup;
      end
`endif
      default: state_d = StIdle;
    endcase

    // Walk the detector toward s==11, then emit the firing 1.
    if (run_setup) begin
      if (!s_d[1]) begin
        x_d     = 1'b1;
        state_d = StSetup;
      end else if (!s_d[0]) begin
        x_d     = 1'b0;
        state_d = StSetup;
      end else begin
        x_d     = 1'b1;
        pm_d    = 1'b1;
        state_d = StFire;
      end
    end
  end

  // State registers with synchronous reset shared with the detector.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      s_q     <= 2'b00;
      x_q     <= 1'b0;
      pm_q    <= 1'b0;
      done_q  <= 1'b0;
      rem_q   <= '0;
`ifdef FSM7_TX_GAP_EN
      gap_q   <= '0;
      gcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      x_q     <= x_d;
      pm_q    <= pm_d;
      done_q  <= done_d;
      rem_q   <= rem_d;
`ifdef FSM7_TX_GAP_EN
      gap_q   <= gap_d;
      gcnt_q  <= gcnt_d;
`endif
    end
  end

  assign cmd_ready_o  = (state_q == StIdle);
  assign busy_o       = (state_q != StIdle);
  assign x_o          = x_q;
  assign pulse_mark_o = pm_q;
  assign done_o       = done_q;

endmodule
